// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker instruction-fetch front end.
package tinker_pkg;

    localparam logic [4:0]  OPC_HALT         = 5'h0f;
    localparam int          INSTR_W          = 32;
    localparam int          ADDR_W           = 64;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h2000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // A halt is identified by its opcode field plus a zero low nibble.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr[31:27] == OPC_HALT) && (instr[3:0] == 4'h0);
    endfunction

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
module tinker_fetch_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/tinker_fetch_unit.sv
// Instruction-fetch front end: issues in-order word fetches, tags responses with
// their PC, buffers them for decode, and handles redirects and halt.
module tinker_fetch_unit
    import tinker_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               halt_seen
);

    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic              halted;

    logic              grant;
    logic              push_en;
    logic              pop_en;
    logic [CW:0]       credit_used;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    // Every slot is either occupied or reserved by an outstanding request,
    // so a response can never find the FIFO full.
    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign imem_req    = !reset && !halted && !redirect_valid &&
                         (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;

    assign push_en   = imem_rvalid && !redirect_valid && (drop == '0) && !halted;
    assign pop_en    = id_valid && id_ready && !redirect_valid;
    assign push_data = '{pc: resp_pc, instr: imem_rdata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            // Whatever is still outstanding after this cycle belongs to the old path.
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            halted   <= 1'b0;
            inflight <= inflight - CW'(imem_rvalid);
            drop     <= inflight - CW'(imem_rvalid);
        end else begin
            if (grant)
                fetch_pc <= fetch_pc + 64'd4;
            inflight <= inflight + CW'(grant) - CW'(imem_rvalid);
            if (imem_rvalid && (drop != '0))
                drop <= drop - 1'b1;
            if (push_en) begin
                resp_pc <= resp_pc + 64'd4;
                if (is_halt(imem_rdata))
                    halted <= 1'b1;
            end
        end
    end

    tinker_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_en),
        .pop      (pop_en),
        .flush    (redirect_valid),
        .push_data(push_data),
        .head     (head),
        .count    (count)
    );

    assign id_valid  = (count != '0);
    assign id_pc     = head.pc;
    assign id_instr  = head.instr;
    assign halt_seen = halted;

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Scoreboard bench for tinker_fetch_unit: a variable-latency memory model feeds
// the DUT, and decode output is compared against the program-order stream.
module tb_tinker_fetch_unit;
    import tinker_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        halt_seen;

    always #5 clk = ~clk;

    tinker_fetch_unit #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .halt_seen     (halt_seen)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    int gnt_pct = 100;
    int outstanding = 0;

    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] halt_map[logic [63:0]];
    logic [63:0] exp_pc[$];
    logic [31:0] exp_instr[$];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Memory image: ordinary words always have bit 31 set so they never decode as halt.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        logic [31:0] h;
        if (halt_map.exists(addr))
            return halt_map[addr];
        h = (addr[31:0] * 32'h9E3779B1) ^ addr[63:32] ^ 32'h5bd1e995;
        return {1'b1, h[30:0]};
    endfunction

    // Program order from a start address: consecutive words up to and including a halt.
    task automatic expect_stream(input logic [63:0] start);
        logic [63:0] pc;
        logic [31:0] w;
        pc = start;
        exp_pc.delete();
        exp_instr.delete();
        for (int i = 0; i < 2048; i++) begin
            w = mem_word(pc);
            exp_pc.push_back(pc);
            exp_instr.push_back(w);
            if (w[31:27] == 5'h0f && w[3:0] == 4'h0)
                break;
            pc = pc + 64'd4;
        end
    endtask

    // One clock: memory presents the oldest due response, then a fresh grant decision.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!reset && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
            outstanding--;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = ($urandom_range(0, 99) < gnt_pct);
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        outstanding = 0;
        expect_stream(RESET_PC);
    endtask

    task automatic apply_stimulus_redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        expect_stream(target);
        step();
        redirect_valid = 1'b0;
    endtask

    // Memory side: record accepted requests with their response due cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_gnt) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + mem_lat);
                outstanding++;
                check_output("credit_limit", 64'(outstanding > DEPTH), 64'd0);
            end
            if (u_dut.push_en && u_dut.count == 3'(DEPTH))
                check_output("push_into_full", 64'd1, 64'd0);
        end
    end

    // Monitor: every decode handshake must match the head of the expected stream.
    always @(negedge clk) begin
        if (!reset && id_valid && id_ready && !redirect_valid) begin
            if (exp_pc.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output actual_pc=0x%0h required=none", id_pc);
            end else begin
                check_output("id_pc", id_pc, exp_pc.pop_front());
                check_output("id_instr", 64'(id_instr), 64'(exp_instr.pop_front()));
            end
        end
    end

    initial begin
        logic [63:0] tgt;
        int          waited;

        // Reset values, then zero-wait memory and the two-cycle first-delivery latency.
        #2;
        apply_reset();
        step();
        step();
        check_output("reset_imem_req", 64'(imem_req), 64'd0);
        check_output("reset_id_valid", 64'(id_valid), 64'd0);
        check_output("reset_halt_seen", 64'(halt_seen), 64'd0);
        mem_lat  = 1;
        gnt_pct  = 100;
        id_ready = 1'b1;
        reset    = 1'b0;
        imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_output("first_req", 64'(imem_req), 64'd1);
                check_output("first_addr", imem_addr, RESET_PC);
            end
            check_output("first_valid_latency", 64'(id_valid), 64'(i == 2));
            step();
        end
        repeat (20) step();

        // Backpressure: credits run out, nothing is lost, drain in order.
        id_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check_output("stall_req_off", 64'(imem_req), 64'd0);
        check_output("stall_valid", 64'(id_valid), 64'd1);
        check_output("stall_head_pc", id_pc, exp_pc[0]);
        id_ready = 1'b1;
        repeat (20) step();

        // Latency 3 with requests in flight, redirect to 0x3000.
        mem_lat = 3;
        repeat (15) step();
        apply_stimulus_redirect(64'h3000);
        waited = 0;
        while (!id_valid && waited < 20) begin
            step();
            waited++;
        end
        @(negedge clk);
        check_output("redirect_first_pc", id_pc, 64'h3000);
        repeat (20) step();

        // Randomised traffic with redirects (incl. wrap and halt regions).
        halt_map[64'h4000_0020] = 32'h7800_0001;
        halt_map[64'h4000_0040] = 32'h7fff_fff0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                mem_lat = $urandom_range(1, 4);
                gnt_pct = $urandom_range(30, 100);
            end
            id_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 3 || (redirect_valid && $urandom_range(0, 99) < 30)) begin
                case ($urandom_range(0, 3))
                    0: tgt = 64'h4000_0000;
                    1: tgt = 64'hFFFF_FFFF_FFFF_FFF0;
                    default: tgt = {$urandom, $urandom} & ~64'h3;
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
                expect_stream(tgt);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        halt_map.delete();

        // Halt at 0x2008: delivered, then fetch stops until a redirect.
        halt_map[64'h2008] = 32'h7800_0000;
        apply_reset();
        step();
        mem_lat  = 1;
        gnt_pct  = 100;
        id_ready = 1'b1;
        reset    = 1'b0;
        waited = 0;
        while (exp_pc.size() != 0 && waited < 60) begin
            step();
            waited++;
        end
        check_output("halt_stream_drained", 64'(exp_pc.size()), 64'd0);
        repeat (10) step();
        @(negedge clk);
        check_output("halt_seen", 64'(halt_seen), 64'd1);
        check_output("halt_req_off", 64'(imem_req), 64'd0);
        check_output("halt_no_output", 64'(id_valid), 64'd0);
        step();
        apply_stimulus_redirect(64'h2100);
        @(negedge clk);
        check_output("halt_cleared", 64'(halt_seen), 64'd0);
        waited = 0;
        while (!id_valid && waited < 20) begin
            step();
            waited++;
        end
        @(negedge clk);
        check_output("resume_pc", id_pc, 64'h2100);
        repeat (20) step();
        halt_map.delete();

        // Reset with the FIFO full: outputs drop at once, fetch restarts at RESET_PC.
        id_ready = 1'b0;
        repeat (12) step();
        @(negedge clk);
        check_output("full_before_reset", 64'(id_valid), 64'd1);
        step();
        apply_reset();
        #1;
        check_output("midreset_id_valid", 64'(id_valid), 64'd0);
        check_output("midreset_imem_req", 64'(imem_req), 64'd0);
        step();
        id_ready = 1'b1;
        reset    = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check_output("restart_addr", imem_addr, RESET_PC);
        check_output("restart_req", 64'(imem_req), 64'd1);
        repeat (30) step();
        check_output("restart_progress", 64'(exp_pc[0] > RESET_PC + 64'h40), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinker_fetch_unit.md
Name: tinker_fetch_unit

Overview:
Instruction-fetch front end that feeds the IF/ID register of the pipelined Tinker core. It issues word fetch requests to instruction memory, which may have variable latency and returns responses in order. Returned instructions are tagged with their PC and buffered in a small FIFO. A ready/valid interface presents them to decode. The block also handles branch redirects from EX, discards stale responses, and stops fetching after a halt instruction.

Parameters:
DEPTH, 4, entries in the {pc, instr} FIFO; also the maximum number of requests in flight (power of two, >=2)
RESET_PC, 64'h2000, first fetch address after reset

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  64  byte address of the requested 32-bit word
imem_gnt  input  1  memory accepts the request this cycle
imem_rvalid  input  1  response data valid (in order, one per granted request)
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  EX-stage PC change (jump/branch/call/return taken)
redirect_pc  input  64  new fetch target
id_valid  output  1  FIFO head valid toward decode
id_ready  input  1  decode accepts the head
id_pc  output  64  PC of the head instruction
id_instr  output  32  head instruction word
halt_seen  output  1  halt instruction enqueued; fetch stopped

Behaviour:
- Reset is asynchronous and active-high: fetch_pc=RESET_PC, resp_pc=RESET_PC, inflight=0, drop=0, count=0, halted=0. During reset: imem_req=0, id_valid=0, halt_seen=0.
- State: fetch_pc (next request address), resp_pc (PC of the next expected response), inflight (granted but not yet returned, 0..DEPTH), drop (stale responses to discard), FIFO count.
- Request issue: imem_req = !halted && !redirect_valid && (inflight + count < DEPTH). imem_req is combinational from registered state and redirect_valid. imem_addr = fetch_pc.
- On imem_req && imem_gnt: fetch_pc += 4 and inflight += 1. The 64-bit add wraps modulo 2^64.
- Response handling: every imem_rvalid decrements inflight. Grant and response in the same cycle leave inflight unchanged.
  - If drop>0: decrement drop; the response is not enqueued.
  - Else if halted: the response is discarded and not enqueued.
  - Else: push {resp_pc, imem_rdata} and set resp_pc += 4.
- Halt detection: a pushed word with [31:27]==5'h0f and [3:0]==4'h0 sets halted=1 in the same cycle. That halt word is itself enqueued. halt_seen=halted.
- Decode handshake: id_valid = (count!=0). id_pc and id_instr come from the FIFO head. The head pops on id_valid && id_ready. Output values are stable while id_valid && !id_ready.
- Redirect (takes priority over everything in its cycle):
  - FIFO flushed (count=0); any pop or push that cycle is ignored.
  - fetch_pc=resp_pc=redirect_pc; halted=0.
  - drop = inflight − (imem_rvalid ? 1 : 0), which covers the response arriving that cycle; inflight updated the same way.
  - No request is issued in the redirect cycle. Back-to-back redirects: the last one wins.
- Latency: with a zero-wait memory (gnt=1, rvalid one cycle after grant), the first id_valid occurs 2 cycles after reset deassert. Steady state is one instruction per cycle while id_ready=1.
- Push into a full FIFO cannot occur because of the credit rule; the bench asserts this.
- Reset asserted mid-operation: all state returns to reset values immediately. Responses arriving after reset are not counted; the memory is reset together with the core.

Decomposition:
- Shared package tinker_pkg holds:
  - OPC_HALT=5'h0f
  - INSTR_W=32, ADDR_W=64
  - DEFAULT_RESET_PC=64'h2000
  - a packed typedef fetch_entry_t {pc[63:0], instr[31:0]}
- Sub-module tinker_fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t. Ports: push, pop, flush, head, count. Pointers wrap at DEPTH; flush resets the pointers and count.

Test Plan:
- Reset, zero-wait memory, id_ready=1 -> id_pc sequence 0x2000, 0x2004, 0x2008… with id_instr matching memory; first id_valid 2 cycles after reset release.
- id_ready=0 for 10 cycles, rvalid latency 1 -> imem_req drops once inflight+count=4; no push is lost; on release, 4 entries drain in order.
- Memory latency 3, redirect_valid with redirect_pc=0x3000 while inflight=3 -> the 3 stale responses are dropped; next id_pc=0x3000.
- Redirect in the same cycle as a pop and an rvalid -> FIFO empty next cycle, drop=inflight−1, no stale word reaches decode.
- Halt word 0x78000000 at 0x2008 -> that word is delivered, halt_seen=1, imem_req=0, later responses are discarded; a redirect to 0x2100 clears halt_seen and fetch resumes.
- Assert reset mid-stream with FIFO full -> id_valid=0 and imem_req=0 immediately; after release, fetch restarts at 0x2000.
